control_unit_pipe: RTL and testbench

- Registered, multi-cycle successor to the combinational opcode decoder.
- Accepts one instruction per valid/ready handshake and registers all datapath control strobes.
- Holds the issue slot for a parametrised multiply latency.
- Resolves branches against the Flags input and emits a flush pulse plus one bubble on any taken branch.
- Sits between instruction fetch and the datapath muxes/ALU/register file/memory.

---
 rtl/control_unit_pipe_pkg.sv | 83 ++++++++
 rtl/control_unit_pipe_decode.sv | 80 ++++++++
 rtl/control_unit_pipe.sv | 129 ++++++++++++
 tb/tb_control_unit_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pipe_pkg.sv
// Shared opcode, ALU and result-select encodings plus the control word and FSM states.
// Pure definitions, no logic.
// Not applicable.
package cu_pkg;

  // Opcode encodings (low 5 bits of Opcode)
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_SUBI = 5'b00011;
  localparam logic [4:0] OP_CMP  = 5'b00100;
  localparam logic [4:0] OP_CMPI = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_XOR  = 5'b01001;
  localparam logic [4:0] OP_LD   = 5'b01010;
  localparam logic [4:0] OP_LDI  = 5'b01011;
  localparam logic [4:0] OP_ST   = 5'b01100;
  localparam logic [4:0] OP_STI  = 5'b01101;
  localparam logic [4:0] OP_MOV  = 5'b01110;
  localparam logic [4:0] OP_MOVI = 5'b01111;
  localparam logic [4:0] OP_SHL  = 5'b10000;
  localparam logic [4:0] OP_SHR  = 5'b10001;
  localparam logic [4:0] OP_ROT  = 5'b10010;
  localparam logic [4:0] OP_JMP  = 5'b10011;
  localparam logic [4:0] OP_JNE  = 5'b10100;
  localparam logic [4:0] OP_JEQ  = 5'b10101;
  localparam logic [4:0] OP_MULT = 5'b10110;
  localparam logic [4:0] OP_NOP  = 5'b10111;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_CMP = 3'b101;
  localparam logic [2:0] ALU_NOT = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b110;
  localparam logic [2:0] ALU_SHL = 3'b111;

  // Result mux encodings
  localparam logic [1:0] RES_MOV = 2'b00;
  localparam logic [1:0] RES_MUL = 2'b01;
  localparam logic [1:0] RES_ALU = 2'b10;
  localparam logic [1:0] RES_MEM = 2'b11;

  typedef enum logic [1:0] {IDLE, MULT_WAIT, FLUSH} cuState_t;

  typedef struct packed {
    logic       muxDireccionPC;
    logic       muxSelDirRegB;
    logic       crtlMuxValA;
    logic       crtlMuxValB;
    logic [2:0] aluCode;
    logic [1:0] muxResult;
    logic       muxDirWrite;
    logic       muxDirMem;
    logic       muxDato;
    logic       writeMem;
    logic       writeReg;
  } ctrlWord_t;

  // Quiescent word: everything off, memory address mux parked on 1
  localparam ctrlWord_t CTRL_RESET = '{
    muxDireccionPC: 1'b0, muxSelDirRegB: 1'b0, crtlMuxValA: 1'b0,
    crtlMuxValB: 1'b0, aluCode: 3'b000, muxResult: 2'b00,
    muxDirWrite: 1'b0, muxDirMem: 1'b1, muxDato: 1'b0,
    writeMem: 1'b0, writeReg: 1'b0};

  // Common shape of every register-writing ALU operation
  function automatic ctrlWord_t aluWord(input logic [2:0] code);
    ctrlWord_t w;
    w           = CTRL_RESET;
    w.aluCode   = code;
    w.muxResult = RES_ALU;
    w.muxDato   = 1'b1;
    w.writeReg  = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/control_unit_pipe_decode.sv
// Combinational opcode + flags decode into a control word, branch-taken, illegal and multiply flags.
// Zero cycles; purely combinational.
// None; the top level decides when the decoded word is captured.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int FLAG_W   = 2
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FLAG_W-1:0]   flags,
  output ctrlWord_t           ctrl,
  output logic                taken,
  output logic                illegal,
  output logic                isMult
);

  logic       upperZero;
  logic [4:0] op5;

  assign op5       = opcode[4:0];
  assign upperZero = ((opcode >> 5) == '0);

  // Map each opcode to its full control word; unknown encodings raise illegal
  always_comb begin
    ctrl    = CTRL_RESET;
    taken   = 1'b0;
    illegal = 1'b0;
    isMult  = 1'b0;
    if (!upperZero) begin
      illegal = 1'b1;
    end else begin
      case (op5)
        OP_ADD, OP_ADDI: begin ctrl = aluWord(ALU_ADD); ctrl.crtlMuxValB = op5[0]; end
        OP_SUB, OP_SUBI: begin ctrl = aluWord(ALU_SUB); ctrl.crtlMuxValB = op5[0]; end
        OP_CMP, OP_CMPI: begin ctrl = aluWord(ALU_CMP); ctrl.crtlMuxValB = op5[0]; end
        OP_AND: ctrl = aluWord(ALU_AND);
        OP_OR:  ctrl = aluWord(ALU_OR);
        OP_NOT: ctrl = aluWord(ALU_NOT);
        OP_XOR: ctrl = aluWord(ALU_XOR);
        OP_SHL: ctrl = aluWord(ALU_SHL);
        OP_LD, OP_LDI: begin
          ctrl.muxResult   = RES_MEM;
          ctrl.muxDirMem   = 1'b0;
          ctrl.writeReg    = 1'b1;
          ctrl.crtlMuxValA = op5[0];
        end
        OP_ST, OP_STI: begin
          ctrl.muxSelDirRegB = 1'b1;
          ctrl.writeMem      = 1'b1;
          ctrl.crtlMuxValA   = op5[0];
        end
        OP_MOV, OP_MOVI: begin
          ctrl.muxResult   = RES_MOV;
          ctrl.muxDato     = 1'b1;
          ctrl.writeReg    = 1'b1;
          ctrl.crtlMuxValA = op5[0];
        end
        OP_MULT: begin
          ctrl.aluCode     = ALU_MUL;
          ctrl.muxResult   = RES_MUL;
          ctrl.muxDirWrite = 1'b1;
          isMult           = 1'b1;
        end
        OP_JMP, OP_JNE, OP_JEQ: begin
          if (op5 == OP_JMP)      taken = 1'b1;
          else if (op5 == OP_JNE) taken = flags[0];
          else                    taken = (flags[1:0] != 2'b01);
          ctrl.muxResult      = RES_MEM;
          ctrl.muxDato        = 1'b1;
          ctrl.muxDireccionPC = taken;
        end
        // SHR and ROT retire as NOPs without an illegal pulse
        OP_NOP, OP_SHR, OP_ROT: ctrl = CTRL_RESET;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/control_unit_pipe.sv
// Registered control unit: decodes one instruction per handshake and drives datapath strobes.
// Latency 1 cycle from accept to ctrl_valid; MULT holds the word for MULT_CYCLES cycles.
// instr_ready drops during MULT, during the taken-branch flush cycle and the following bubble.
module control_unit_pipe
  import cu_pkg::*;
#(
  parameter int OPCODE_W    = 5,
  parameter int ALU_W       = 3,
  parameter int FLAG_W      = 2,
  parameter int MULT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic [FLAG_W-1:0]   Flags,
  output logic                ctrl_valid,
  output logic                MuxDireccionPC,
  output logic                MuxSelDirRegB,
  output logic                crtlMuxValA,
  output logic                crtlMuxValB,
  output logic [ALU_W-1:0]    CodigoALUIN,
  output logic [1:0]          MuxResultIN,
  output logic                MuxDirWriteIN,
  output logic                MuxDirMemIN,
  output logic                MuxDatoIN,
  output logic                WriteMemIN,
  output logic                WriteRegIN,
  output logic                flush,
  output logic                illegal_op
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);

  cuState_t  state;
  ctrlWord_t ctrlReg, decWord, acceptWord;
  logic      decTaken, decIllegal, decMult;
  logic      ctrlValidReg, flushReg, illegalReg, accept;
  logic [3:0] multCnt;

  cu_decode #(.OPCODE_W(OPCODE_W), .FLAG_W(FLAG_W)) uDecode (
    .opcode (Opcode),
    .flags  (Flags),
    .ctrl   (decWord),
    .taken  (decTaken),
    .illegal(decIllegal),
    .isMult (decMult)
  );

  // Ready only when idle and not in the flush cycle, where fetch's in-flight word is stale
  assign instr_ready = rst_n && (state == IDLE) && !flushReg;
  assign accept      = instr_valid && instr_ready;

  // A multi-cycle MULT writes the register file only on its final cycle
  always_comb begin
    acceptWord = decWord;
    if (decMult) acceptWord.writeReg = (MULT_CYCLES == 1);
  end

  // FSM, multiply counter and registered control outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      ctrlReg      <= CTRL_RESET;
      multCnt      <= '0;
      ctrlValidReg <= 1'b0;
      flushReg     <= 1'b0;
      illegalReg   <= 1'b0;
    end else begin
      flushReg   <= 1'b0;
      illegalReg <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ctrlReg      <= acceptWord;
            ctrlValidReg <= 1'b1;
            flushReg     <= decTaken;
            illegalReg   <= decIllegal;
            if (decMult && (MULT_CYCLES > 1)) begin
              state   <= MULT_WAIT;
              multCnt <= MULT_LOAD;
            end
          end else begin
            if (flushReg) state <= FLUSH;
            ctrlValidReg           <= 1'b0;
            ctrlReg.writeMem       <= 1'b0;
            ctrlReg.writeReg       <= 1'b0;
            ctrlReg.muxDireccionPC <= 1'b0;
          end
        end
        MULT_WAIT: begin
          if (multCnt == 4'd0) begin
            state            <= IDLE;
            ctrlValidReg     <= 1'b0;
            ctrlReg.writeReg <= 1'b0;
          end else begin
            multCnt          <= multCnt - 4'd1;
            ctrlReg.writeReg <= (multCnt == 4'd1);
          end
        end
        FLUSH: begin
          state                  <= IDLE;
          ctrlValidReg           <= 1'b0;
          ctrlReg.writeMem       <= 1'b0;
          ctrlReg.writeReg       <= 1'b0;
          ctrlReg.muxDireccionPC <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ctrl_valid     = ctrlValidReg;
  assign MuxDireccionPC = ctrlReg.muxDireccionPC;
  assign MuxSelDirRegB  = ctrlReg.muxSelDirRegB;
  assign crtlMuxValA    = ctrlReg.crtlMuxValA;
  assign crtlMuxValB    = ctrlReg.crtlMuxValB;
  assign CodigoALUIN    = ALU_W'(ctrlReg.aluCode);
  assign MuxResultIN    = ctrlReg.muxResult;
  assign MuxDirWriteIN  = ctrlReg.muxDirWrite;
  assign MuxDirMemIN    = ctrlReg.muxDirMem;
  assign MuxDatoIN      = ctrlReg.muxDato;
  assign WriteMemIN     = ctrlReg.writeMem;
  assign WriteRegIN     = ctrlReg.writeReg;
  assign flush          = flushReg;
  assign illegal_op     = illegalReg;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Scoreboard bench for control_unit_pipe: directed opcodes, expected words queued at issue.
// Monitor compares every ctrl_valid cycle on the falling edge.
// Handshake waits are bounded; expiry counts as an error.
module tb_control_unit_pipe;

  typedef struct packed {
    logic       pc, selB, valA, valB;
    logic [2:0] alu;
    logic [1:0] res;
    logic       dirW, dirMem, dato, wMem, wReg, flsh, ill;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [4:0] Opcode = 5'd0;
  logic [1:0] Flags = 2'd0;
  logic       ctrl_valid, MuxDireccionPC, MuxSelDirRegB, crtlMuxValA, crtlMuxValB;
  logic [2:0] CodigoALUIN;
  logic [1:0] MuxResultIN;
  logic       MuxDirWriteIN, MuxDirMemIN, MuxDatoIN, WriteMemIN, WriteRegIN, flush, illegal_op;

  obs_t obs;
  obs_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   popIdx = 0;
  logic monOn = 1'b0;

  control_unit_pipe #(.OPCODE_W(5), .ALU_W(3), .FLAG_W(2), .MULT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .Opcode(Opcode), .Flags(Flags), .ctrl_valid(ctrl_valid),
    .MuxDireccionPC(MuxDireccionPC), .MuxSelDirRegB(MuxSelDirRegB),
    .crtlMuxValA(crtlMuxValA), .crtlMuxValB(crtlMuxValB), .CodigoALUIN(CodigoALUIN),
    .MuxResultIN(MuxResultIN), .MuxDirWriteIN(MuxDirWriteIN), .MuxDirMemIN(MuxDirMemIN),
    .MuxDatoIN(MuxDatoIN), .WriteMemIN(WriteMemIN), .WriteRegIN(WriteRegIN),
    .flush(flush), .illegal_op(illegal_op));

  always #5 clk = ~clk;

  assign obs = {MuxDireccionPC, MuxSelDirRegB, crtlMuxValA, crtlMuxValB, CodigoALUIN,
                MuxResultIN, MuxDirWriteIN, MuxDirMemIN, MuxDatoIN, WriteMemIN,
                WriteRegIN, flush, illegal_op};

  function automatic obs_t base();
    obs_t o;
    o        = '0;
    o.dirMem = 1'b1;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  // Present an instruction and hold it until accepted; returns the number of not-ready edges
  task automatic issue(input logic [4:0] op, input logic [1:0] fl, output int waits);
    logic rdy;
    waits       = 0;
    instr_valid = 1'b1;
    Opcode      = op;
    Flags       = fl;
    rdy         = 1'b0;
    while (!rdy) begin
      rdy = instr_ready;
      @(posedge clk); #1;
      if (!rdy) begin
        waits++;
        if (waits > 50) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout op=%b got=no_accept required=accept", op);
          rdy = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Taken branch: one cycle after the flush pulse the block must refuse, then recover
  task automatic bubbleCheck(input string name);
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk({name, "_bubble_ready"}, 32'(instr_ready), 32'd0);
    @(posedge clk); #1;
    chk({name, "_recover_ready"}, 32'(instr_ready), 32'd1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (monOn) begin
      if (ctrl_valid) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ctrl got=%h required=no_ctrl_valid", obs);
        end else begin
          obs_t e;
          e = expQ.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL ctrl_word_%0d got=%h required=%h", popIdx, obs, e);
          end
          popIdx++;
        end
      end else begin
        checks++;
        if ({WriteMemIN, WriteRegIN, MuxDireccionPC, flush, illegal_op} !== 5'b0) begin
          errors++;
          $display("FAIL idle_strobes got=%b required=00000",
                   {WriteMemIN, WriteRegIN, MuxDireccionPC, flush, illegal_op});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e;
    int   w;

    // Reset held for three edges
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(obs), 32'(base()));
    chk("reset_ctrl_valid", 32'(ctrl_valid), 32'd0);
    chk("reset_ready", 32'(instr_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("release_ready", 32'(instr_ready), 32'd1);
    chk("release_ctrl_valid", 32'(ctrl_valid), 32'd0);
    monOn = 1'b1;

    // Back-to-back ADD, SUBI, LD, ST
    e = base(); e.alu = 3'b011; e.res = 2'b10; e.dato = 1; e.wReg = 1; expQ.push_back(e);
    e = base(); e.alu = 3'b100; e.valB = 1; e.res = 2'b10; e.dato = 1; e.wReg = 1; expQ.push_back(e);
    e = base(); e.res = 2'b11; e.dirMem = 0; e.wReg = 1; expQ.push_back(e);
    e = base(); e.selB = 1; e.wMem = 1; expQ.push_back(e);
    issue(5'b00000, 2'b00, w); chk("stream_add_wait", 32'(w), 32'd0);
    issue(5'b00011, 2'b00, w); chk("stream_subi_wait", 32'(w), 32'd0);
    issue(5'b01010, 2'b00, w); chk("stream_ld_wait", 32'(w), 32'd0);
    issue(5'b01100, 2'b00, w); chk("stream_st_wait", 32'(w), 32'd0);
    idle(2);

    // MULT occupies four cycles, ADD waits behind it
    for (int i = 0; i < 4; i++) begin
      e = base(); e.alu = 3'b110; e.res = 2'b01; e.dirW = 1; e.wReg = (i == 3);
      expQ.push_back(e);
    end
    e = base(); e.alu = 3'b011; e.res = 2'b10; e.dato = 1; e.wReg = 1; expQ.push_back(e);
    issue(5'b10110, 2'b00, w); chk("mult_accept_wait", 32'(w), 32'd0);
    issue(5'b00000, 2'b00, w); chk("add_after_mult_wait", 32'(w), 32'd4);
    idle(2);

    // Branches
    e = base(); e.pc = 1; e.res = 2'b11; e.dato = 1; e.flsh = 1; expQ.push_back(e);
    issue(5'b10100, 2'b01, w);
    bubbleCheck("jne_taken");
    e = base(); e.res = 2'b11; e.dato = 1; expQ.push_back(e);
    issue(5'b10100, 2'b00, w);
    e = base(); e.res = 2'b11; e.dato = 1; expQ.push_back(e);
    issue(5'b10101, 2'b01, w);
    idle(1);
    e = base(); e.pc = 1; e.res = 2'b11; e.dato = 1; e.flsh = 1; expQ.push_back(e);
    issue(5'b10101, 2'b10, w);
    bubbleCheck("jeq_taken");

    // Illegal opcode, SHR as NOP, MOVI, STI
    e = base(); e.ill = 1; expQ.push_back(e);
    e = base(); expQ.push_back(e);
    e = base(); e.res = 2'b00; e.dato = 1; e.wReg = 1; e.valA = 1; expQ.push_back(e);
    e = base(); e.selB = 1; e.wMem = 1; e.valA = 1; expQ.push_back(e);
    issue(5'b11111, 2'b00, w);
    issue(5'b10001, 2'b00, w);
    issue(5'b01111, 2'b00, w);
    issue(5'b01101, 2'b00, w);
    idle(2);

    // Reset asserted during MULT cycle 2: no write strobe, reset values afterwards
    for (int i = 0; i < 2; i++) begin
      e = base(); e.alu = 3'b110; e.res = 2'b01; e.dirW = 1; expQ.push_back(e);
    end
    issue(5'b10110, 2'b00, w);
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midmult_reset_outputs", 32'(obs), 32'(base()));
    chk("midmult_reset_valid", 32'(ctrl_valid), 32'd0);
    chk("midmult_reset_ready", 32'(instr_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    e = base(); e.alu = 3'b011; e.res = 2'b10; e.dato = 1; e.wReg = 1; expQ.push_back(e);
    issue(5'b00000, 2'b00, w); chk("post_reset_add_wait", 32'(w), 32'd0);
    idle(3);

    chk("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
